// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and the fetch packet type for the MIPS-RISC32 front end
package mips_pkg;
   localparam int INSTR_W = 32;
   localparam int WORD_BYTES = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   typedef struct packed {
      logic [31:0]        pc;
      logic [INSTR_W-1:0] instr;
   } fetch_pkt_t;
endpackage

// File: rtl/if_fifo2.sv
// if_fifo2: two-entry fetch-packet skid FIFO with synchronous flush and same-cycle push/pop
module if_fifo2
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       push,
   input  logic       pop,
   input  fetch_pkt_t push_pkt,
   output fetch_pkt_t head,
   output logic [1:0] count
);
   fetch_pkt_t slot0, slot1;
   assign head = slot0;
   // occupancy; reset and flush both empty the queue, dropping any concurrent push
   always_ff @(posedge clk)
      if (rst || flush) count <= 2'd0;
      else count <= count + 2'(push) - 2'(pop);
   // slot0 is always the head; slot1 only matters when two entries are held
   always_ff @(posedge clk) begin
      slot0 <= pop ? ((count == 2'd2) ? slot1 : push_pkt) : (push && count == 2'd0) ? push_pkt : slot0;
      slot1 <= push ? push_pkt : slot1;
   end
   // the issue rule upstream must never let the queue overflow or underflow
   always_ff @(posedge clk)
      if (!rst && !flush) begin
         assert (!(push && !pop && count == 2'd2));
         assert (!(pop && count == 2'd0));
      end
endmodule

// File: rtl/mips_if_stage.sv
// mips_if_stage: PC, iMem request issue and buffered instruction hand-off to decode
module mips_if_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          IMEM_AW  = 10
) (
   input  logic               clk,
   input  logic               resetn,
   output logic               imem_en,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_rdata,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   input  logic               id_ready,
   output logic               if_valid,
   output logic [31:0]        if_instr,
   output logic [31:0]        if_pc,
   output logic [31:0]        if_pc_plus4,
   output logic               misaligned_err
);
   logic [31:0] pc, req_pc;
   logic        inflight, pop, push;
   logic [1:0]  count;
   logic [2:0]  occ;
   fetch_pkt_t  head;
   assign if_valid    = !resetn && count != 2'd0;
   assign if_instr    = if_valid ? head.instr : '0;
   assign if_pc       = if_valid ? head.pc : '0;
   assign if_pc_plus4 = if_pc + 32'(WORD_BYTES);
   assign pop         = if_valid && id_ready;
   assign push        = !resetn && inflight && !redirect_valid;
   assign occ         = 3'(count) + 3'(inflight) - 3'(pop);
   assign imem_en     = !resetn && !redirect_valid && !misaligned_err && occ < 3'd2;
   assign imem_addr   = pc[IMEM_AW+1:2];
   // PC, outstanding-request tracking and the sticky misalignment halt
   always_ff @(posedge clk)
      if (resetn) begin
         pc             <= RESET_PC;
         req_pc         <= RESET_PC;
         inflight       <= 1'b0;
         misaligned_err <= 1'b0;
      end else begin
         inflight <= imem_en;
         if (redirect_valid) begin
            pc <= redirect_pc;
            if (redirect_pc[1:0] != 2'b00) misaligned_err <= 1'b1;
         end else if (imem_en) begin
            pc     <= pc + 32'(WORD_BYTES);
            req_pc <= pc;
         end
      end
   if_fifo2 u_fifo (
      .clk     (clk),
      .rst     (resetn),
      .flush   (redirect_valid),
      .push    (push),
      .pop     (pop),
      .push_pkt('{pc: req_pc, instr: imem_rdata}),
      .head    (head),
      .count   (count)
   );
endmodule

// File: tb/tb_mips_if_stage.sv
// tb_mips_if_stage: table vectors, corner sequences and a program-order scoreboard for mips_if_stage
module tb_mips_if_stage;
   logic        clk = 0;
   logic        resetn, imem_en, redirect_valid, id_ready, if_valid, misaligned_err;
   logic [9:0]  imem_addr;
   logic [31:0] imem_rdata, redirect_pc, if_instr, if_pc, if_pc_plus4;
   logic [31:0] mem [0:1023];
   int n_pass = 0, n_total = 0, pops = 0;
   logic [31:0] exp_pc = 0, hold_pc = 0;
   logic        hold_prev = 0;
   typedef struct {
      logic        id_ready;
      logic        en;
      logic [9:0]  addr;
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } vec_t;
   vec_t tbl [6];

   always #5 clk = ~clk;

   mips_if_stage #(.RESET_PC(32'h0), .IMEM_AW(10)) dut (
      .clk(clk), .resetn(resetn), .imem_en(imem_en), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_ready(id_ready), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .if_pc_plus4(if_pc_plus4), .misaligned_err(misaligned_err)
   );

   always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      id_ready = 1;
      repeat (n) tick();
   endtask

   // Program-order model: every accepted instruction must be the next sequential
   // PC since the last reset/redirect, carrying that PC's memory word.
   always @(negedge clk) begin
      if (resetn) begin
         chk("rst_if_valid", if_valid, 0);
         chk("rst_imem_en", imem_en, 0);
         exp_pc = 32'h0;
         hold_prev = 0;
      end else begin
         if (hold_prev) begin
            chk("hold_valid", if_valid, 1);
            chk("hold_pc", if_pc, hold_pc);
         end
         hold_prev = if_valid && !id_ready && !redirect_valid;
         hold_pc = if_pc;
         if (if_valid && id_ready) begin
            chk("sb_pc", if_pc, exp_pc);
            chk("sb_instr", if_instr, mem[exp_pc[11:2]]);
            chk("sb_pc_plus4", if_pc_plus4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            pops++;
         end
         if (redirect_valid) exp_pc = redirect_pc;
      end
   end

   initial begin
      int start_pops;
      for (int i = 0; i < 1024; i++) mem[i] = {16'hC0DE, 6'd0, i[9:0]};
      mem[0] = 32'h2008_0001;
      mem[1] = 32'h2009_0002;
      mem[2] = 32'h0109_5020;
      mem[3] = 32'h0000_0000;
      tbl[0] = '{1, 1, 10'd0, 0, 32'h0, 32'h0};
      tbl[1] = '{1, 1, 10'd1, 0, 32'h0, 32'h0};
      tbl[2] = '{1, 1, 10'd2, 1, 32'h0, 32'h2008_0001};
      tbl[3] = '{1, 1, 10'd3, 1, 32'h4, 32'h2009_0002};
      tbl[4] = '{1, 1, 10'd4, 1, 32'h8, 32'h0109_5020};
      tbl[5] = '{1, 1, 10'd5, 1, 32'hC, 32'h0000_0000};
      resetn = 1; id_ready = 0; redirect_valid = 0; redirect_pc = 0;
      tick();
      @(negedge clk);
      chk("rst_err", misaligned_err, 0);
      tick();
      resetn = 0;
      for (int i = 0; i < 6; i++) begin
         id_ready = tbl[i].id_ready;
         @(negedge clk);
         chk($sformatf("tbl%0d_en", i), imem_en, tbl[i].en);
         chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
         chk($sformatf("tbl%0d_valid", i), if_valid, tbl[i].valid);
         chk($sformatf("tbl%0d_pc", i), if_pc, tbl[i].pc);
         chk($sformatf("tbl%0d_instr", i), if_instr, tbl[i].instr);
         tick();
      end
      // decode stall: FIFO fills, fetch stops, head holds
      id_ready = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_en", imem_en, 0);
         chk("stall_valid", if_valid, 1);
         chk("stall_pc", if_pc, 32'h10);
         chk("stall_instr", if_instr, mem[4]);
         tick();
      end
      run(6);
      // redirect with a response in flight
      redirect_valid = 1; redirect_pc = 32'h40;
      @(negedge clk);
      chk("redir_en", imem_en, 0);
      tick();
      redirect_valid = 0;
      @(negedge clk);
      chk("redir1_valid", if_valid, 0);
      chk("redir1_en", imem_en, 1);
      chk("redir1_addr", imem_addr, 10'h10);
      tick();
      @(negedge clk);
      chk("redir2_valid", if_valid, 0);
      tick();
      @(negedge clk);
      chk("redir3_valid", if_valid, 1);
      chk("redir3_pc", if_pc, 32'h40);
      chk("redir3_instr", if_instr, mem[16]);
      tick();
      run(4);
      // misaligned redirect halts fetch until reset
      redirect_valid = 1; redirect_pc = 32'h42;
      tick();
      redirect_valid = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("mis_err", misaligned_err, 1);
         chk("mis_valid", if_valid, 0);
         chk("mis_en", imem_en, 0);
         tick();
      end
      resetn = 1;
      tick();
      resetn = 0;
      @(negedge clk);
      chk("mis_clr_err", misaligned_err, 0);
      chk("mis_clr_en", imem_en, 1);
      chk("mis_clr_addr", imem_addr, 10'h0);
      tick();
      run(6);
      // wrap past the top of the address space
      redirect_valid = 1; redirect_pc = 32'hFFFF_FFF8;
      tick();
      redirect_valid = 0;
      @(negedge clk); chk("wrap_addr0", imem_addr, 10'h3FE); tick();
      @(negedge clk); chk("wrap_addr1", imem_addr, 10'h3FF); tick();
      @(negedge clk); chk("wrap_addr2", imem_addr, 10'h000); chk("wrap_pc0", if_pc, 32'hFFFF_FFF8); tick();
      @(negedge clk); chk("wrap_pc1", if_pc, 32'hFFFF_FFFC); chk("wrap_p4", if_pc_plus4, 32'h0); tick();
      @(negedge clk); chk("wrap_pc2", if_pc, 32'h0000_0000); tick();
      run(4);
      // reset mid-stream with buffered and in-flight words
      id_ready = 0; resetn = 1;
      @(negedge clk);
      chk("mrst_valid", if_valid, 0);
      chk("mrst_en", imem_en, 0);
      tick();
      resetn = 0; id_ready = 1;
      @(negedge clk);
      chk("mrst0_en", imem_en, 1);
      chk("mrst0_addr", imem_addr, 10'h0);
      chk("mrst0_valid", if_valid, 0);
      tick();
      @(negedge clk); chk("mrst1_valid", if_valid, 0); tick();
      @(negedge clk); chk("mrst2_valid", if_valid, 1); chk("mrst2_pc", if_pc, 32'h0); tick();
      // random traffic against the program-order model
      start_pops = pops;
      for (int i = 0; i < 2000; i++) begin
         id_ready = $urandom_range(0, 9) < 7;
         redirect_valid = $urandom_range(0, 99) < 3;
         redirect_pc = $urandom & 32'hFFFF_FFFC;
         tick();
      end
      redirect_valid = 0;
      chk("rand_liveness", 32'(pops - start_pops > 500), 1);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/mips_if_stage.md
Name: mips_if_stage

Overview:
Instruction-fetch stage of the MIPS-RISC32 core. It holds the PC, issues word reads to the synchronous instruction memory (iMem, 1-cycle read latency), and buffers returned words in a 2-entry skid FIFO. Instructions go to decode over a valid/ready handshake. Decode/execute can redirect the PC (branch/jump), which flushes all fetched-but-unconsumed work.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned)
IMEM_AW, 10, iMem word-address width (depth = 2**IMEM_AW words)

Ports:
clk  in  1  core clock; all state updates on posedge
resetn  in  1  synchronous reset, active-high (1 = reset); sampled on posedge clk only
imem_en  out  1  iMem read enable for this cycle
imem_addr  out  IMEM_AW  iMem word address = pc[IMEM_AW+1:2]
imem_rdata  in  32  read data; valid the cycle after imem_en=1
redirect_valid  in  1  load redirect_pc into PC and flush
redirect_pc  in  32  target PC
id_ready  in  1  decode accepts the head instruction this cycle
if_valid  out  1  if_instr/if_pc are valid
if_instr  out  32  instruction word
if_pc  out  32  PC of if_instr
if_pc_plus4  out  32  if_pc + 4 (mod 2^32)
misaligned_err  out  1  sticky: redirect to a non-word-aligned PC was seen

Behaviour:
- Reset (resetn=1 at posedge): pc=RESET_PC; FIFO empty; in-flight flag cleared; misaligned_err=0. While reset is held, imem_en=0 and if_valid=0. An in-flight response is discarded at reset, including reset asserted mid-stream.
- Outputs: if_valid/if_instr/if_pc come from the FIFO head (registered, no rdata bypass). if_instr=0 and if_pc=0 when the FIFO is empty. imem_en/imem_addr are combinational from state.
- Pop: pop = if_valid & id_ready. Pop is independent of stall history. Head data stays stable while if_valid=1 and id_ready=0.
- Issue rule: imem_en=1 iff all of: not in reset, not redirect_valid, not misaligned_err, and (fifo_count + inflight - pop) < 2. On issue: pc <= pc+4 (wraps 32'hFFFF_FFFC -> 0), inflight <= 1, and the issued PC is recorded with the request.
- Response: in the cycle after an issue (inflight=1), imem_rdata and the recorded PC are pushed to the FIFO unless killed. Push and pop in the same cycle are allowed. Overflow is impossible by the issue rule; an overflow is an assertion failure.
- Latency: first issue occurs in the first cycle with resetn=0 (addr = RESET_PC>>2). if_valid rises 2 cycles later. Sustained throughput is 1 instr/cycle while id_ready=1.
- Redirect (highest priority after reset): in the cycle redirect_valid=1:
  - FIFO flushed (if_valid=0 next cycle);
  - any in-flight response arriving next cycle is dropped;
  - no issue this cycle;
  - pc <= redirect_pc.
  The first issue at the new PC happens the next cycle. Pop in a redirect cycle is still honoured (decode consumed it). Back-to-back redirects: the last one wins.
- Misaligned redirect (redirect_pc[1:0] != 0): misaligned_err <= 1 (sticky until reset), FIFO flushed, fetch halts permanently until reset.
- Address aliasing: pc bits above IMEM_AW+1 are ignored for imem_addr; if_pc always carries the full 32-bit PC.
- States (implicit in inflight/count): IDLE_RESET, RUN, HALT_ERR. RUN->HALT_ERR on misaligned redirect. Any state -> IDLE_RESET on resetn. IDLE_RESET->RUN on resetn deassert.

Decomposition:
- Shared package mips_pkg: INSTR_W=32, WORD_BYTES=4, default RESET_PC constant, and a typedef for the fetch packet {pc[31:0], instr[31:0]}.
- One sub-module: if_fifo2, a 2-entry fetch-packet FIFO with synchronous flush, simultaneous push/pop, and count output. The PC/issue logic stays in mips_if_stage.

Test Plan:
- Reset release, iMem[0..3]=0x20080001,0x20090002,0x01095020,0x00000000, id_ready=1 -> imem_addr 0,1,2,3 on consecutive cycles; if_valid from cycle 2; if_pc 0,4,8,C with matching instr, one per cycle.
- id_ready=0 for 5 cycles mid-stream -> FIFO fills to 2 and imem_en=0; if_instr holds; no instruction lost or duplicated on release.
- redirect_valid=1, redirect_pc=0x40, with one response in flight -> dropped word never appears; next if_valid shows if_pc=0x40 with iMem[16] contents, exactly 3 cycles after the redirect cycle.
- redirect_pc=0x42 -> misaligned_err=1 the next cycle; if_valid=0 and imem_en=0 thereafter until reset; reset clears misaligned_err.
- redirect_pc=0xFFFF_FFF8, IMEM_AW=10 -> if_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; imem_addr 0x3FE, 0x3FF, 0x000.
- resetn asserted for 1 cycle while FIFO holds 2 entries and a read is in flight -> if_valid=0 during reset; after release the first if_pc=RESET_PC and no stale word is emitted.
